// File: rtl/la_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : la_framer_pkg
//  Description : Shared types and constants for the LA/AS AXI-Stream framer:
//                FSM state encoding, header field offsets, m_tuser encodings
//                and the burst-length clamp helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package la_framer_pkg;

   // Framer FSM states
   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PAYLOAD = 1'b1
   } framer_state_t;

   // Header beat field offsets within m_tdata
   localparam int LEN_LSB = 16;
   localparam int SEQ_LSB = 0;

   // m_tuser encodings
   localparam logic TUSER_HDR = 1'b1;
   localparam logic TUSER_PAY = 1'b0;

   // Zero is promoted to one beat; anything above the ceiling is capped.
   function automatic logic [7:0] clamp_len(input logic [7:0] len,
                                            input logic [7:0] max_len);
      logic [7:0] res;
      res = len;
      if (len == 8'd0) begin
         res = 8'd1;
      end else if (len > max_len) begin
         res = max_len;
      end
      return res;
   endfunction

   // Header payload: {len[7:0], seq[15:0]} packed at the field offsets.
   function automatic logic [23:0] hdr_fields(input logic [7:0]  len,
                                              input logic [15:0] seq);
      logic [23:0] f;
      f = '0;
      f[LEN_LSB +: 8]  = len;
      f[SEQ_LSB +: 16] = seq;
      return f;
   endfunction

endpackage
`default_nettype wire

// File: rtl/la_framer_tmo.sv
`default_nettype none
// ============================================================================
//  Module      : la_framer_tmo
//  Description : Saturating idle-cycle counter for the framer timeout.
//                Clear has priority over increment; o_match is raised when a
//                non-zero limit equals the current count.
//  Revision    : 1.0 - initial release
// ============================================================================
module la_framer_tmo #(
   parameter int TMO_W = 8
) (
   input  logic             axis_clk,
   input  logic             axi_reset,
   input  logic             i_clr,
   input  logic             i_inc,
   input  logic [TMO_W-1:0] i_limit,
   output logic             o_match
);

   logic [TMO_W-1:0] r_cnt;

   // Idle counter: clear wins, otherwise count up and stick at all-ones
   always_ff @(posedge axis_clk) begin
      if (axi_reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + TMO_W'(1);
      end
   end

   // A zero limit disables the timeout entirely
   assign o_match = (i_limit != '0) && (r_cnt == i_limit);

endmodule
`default_nettype wire

// File: rtl/la_axis_framer.sv
`default_nettype none
// ============================================================================
//  Module      : la_axis_framer
//  Description : Drains the LA/AS sample FIFO and emits AXI-Stream packets of
//                a programmable number of payload beats, closing short packets
//                after an idle timeout. A one-entry hold register delays each
//                sample until its m_tlast value is known.
//                Build option: define FRAMER_HDR_EN to prefix every packet
//                with a header beat {len, seq} flagged by m_tuser=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module la_axis_framer
   import la_framer_pkg::*;
#(
   parameter int WIDTH     = 45,
   parameter int MAX_BURST = 16,
   parameter int TMO_W     = 8
) (
   input  logic             axis_clk,
   input  logic             axi_reset,
   input  logic             enable,
   input  logic             f_vld,
   output logic             f_rdy,
   input  logic [WIDTH-1:0] f_data,
   input  logic [7:0]       burst_len,
   input  logic [TMO_W-1:0] tmo_reg,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic [WIDTH-1:0] m_tdata,
   output logic             m_tlast,
   output logic             m_tuser,
   output logic [15:0]      pkt_seq,
   output logic             short_pkt
);

   localparam logic [7:0] c_max_len = 8'(MAX_BURST);

   framer_state_t    r_state;
   logic [WIDTH-1:0] r_hold;
   logic [7:0]       r_cnt;
   logic [7:0]       r_len_l;
   logic             r_tvalid;
   logic [WIDTH-1:0] r_tdata;
   logic             r_tlast;
   logic [15:0]      r_pkt_seq;
   logic             r_short_pkt;

   logic             w_out_free;
   logic             w_more;
   logic             w_f_rdy;
   logic             w_accept;
   logic             w_full_close;
   logic             w_tmo_close;
   logic             w_tmo_match;
   logic [7:0]       w_len_clamp;

   assign w_out_free  = !r_tvalid || m_tready;
   assign w_more      = (r_cnt < r_len_l);
   assign w_len_clamp = clamp_len(burst_len, c_max_len);

   // FIFO read-ready: IDLE only needs room downstream, PAYLOAD also needs a
   // pending entry and a packet that is not yet full
   always_comb begin
      w_f_rdy = 1'b0;
      if (r_state == IDLE) begin
         w_f_rdy = enable && w_out_free;
      end else begin
         w_f_rdy = w_out_free && f_vld && w_more;
      end
   end

   assign w_accept     = w_f_rdy && f_vld;
   assign w_full_close = (r_state == PAYLOAD) && !w_more && w_out_free;
   // An accept in the same cycle restarts the idle window instead
   assign w_tmo_close  = (r_state == PAYLOAD) && w_more && w_tmo_match &&
                         w_out_free && !w_accept;

   la_framer_tmo #(
      .TMO_W (TMO_W)
   ) u_tmo (
      .axis_clk  (axis_clk),
      .axi_reset (axi_reset),
      .i_clr     (w_accept),
      .i_inc     (r_state == PAYLOAD),
      .i_limit   (tmo_reg),
      .o_match   (w_tmo_match)
   );

`ifdef FRAMER_HDR_EN
   logic             r_tuser;
   logic [WIDTH-1:0] w_hdr;

   // Header beat image for the packet about to start
   always_comb begin
      w_hdr       = '0;
      w_hdr[23:0] = hdr_fields(w_len_clamp, r_pkt_seq);
   end
`endif

   // Framer FSM with hold and output registers; the output register is only
   // reloaded when it is free, so a stalled beat never changes
   always_ff @(posedge axis_clk) begin
      if (axi_reset) begin
         r_state     <= IDLE;
         r_hold      <= '0;
         r_cnt       <= '0;
         r_len_l     <= '0;
         r_tvalid    <= 1'b0;
         r_tdata     <= '0;
         r_tlast     <= 1'b0;
         r_pkt_seq   <= '0;
         r_short_pkt <= 1'b0;
`ifdef FRAMER_HDR_EN
         r_tuser     <= TUSER_PAY;
`endif
      end else begin
         r_short_pkt <= 1'b0;
         if (w_out_free) begin
            r_tvalid <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_hold  <= f_data;
                  r_cnt   <= 8'd1;
                  r_len_l <= w_len_clamp;
                  r_state <= PAYLOAD;
`ifdef FRAMER_HDR_EN
                  r_tvalid <= 1'b1;
                  r_tdata  <= w_hdr;
                  r_tlast  <= 1'b0;
                  r_tuser  <= TUSER_HDR;
`endif
               end
            end
            PAYLOAD: begin
               if (w_accept) begin
                  r_tvalid <= 1'b1;
                  r_tdata  <= r_hold;
                  r_tlast  <= 1'b0;
                  r_hold   <= f_data;
                  r_cnt    <= r_cnt + 8'd1;
`ifdef FRAMER_HDR_EN
                  r_tuser  <= TUSER_PAY;
`endif
               end else if (w_full_close || w_tmo_close) begin
                  r_tvalid    <= 1'b1;
                  r_tdata     <= r_hold;
                  r_tlast     <= 1'b1;
                  r_pkt_seq   <= r_pkt_seq + 16'd1;
                  r_short_pkt <= w_tmo_close;
                  r_state     <= IDLE;
`ifdef FRAMER_HDR_EN
                  r_tuser     <= TUSER_PAY;
`endif
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign f_rdy     = w_f_rdy;
   assign m_tvalid  = r_tvalid;
   assign m_tdata   = r_tdata;
   assign m_tlast   = r_tlast;
   assign pkt_seq   = r_pkt_seq;
   assign short_pkt = r_short_pkt;
`ifdef FRAMER_HDR_EN
   assign m_tuser   = r_tuser;
`else
   assign m_tuser   = TUSER_PAY;
`endif

endmodule
`default_nettype wire

// File: tb/tb_la_axis_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_la_axis_framer
//  Description : Directed self-checking bench for la_axis_framer. A queue
//                models the sample FIFO, a monitor records every AXI-Stream
//                handshake, and expected packets are written out by hand.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_la_axis_framer;

   localparam int WIDTH     = 45;
   localparam int MAX_BURST = 16;
   localparam int TMO_W     = 8;
`ifdef FRAMER_HDR_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif

   typedef logic [WIDTH+1:0] beat_t;   // {tuser, tlast, tdata}

   logic             axis_clk = 1'b0;
   logic             axi_reset = 1'b1;
   logic             enable = 1'b0;
   logic             f_vld = 1'b0;
   logic             f_rdy;
   logic [WIDTH-1:0] f_data = '0;
   logic [7:0]       burst_len = '0;
   logic [TMO_W-1:0] tmo_reg = '0;
   logic             m_tvalid;
   logic             m_tready = 1'b0;
   logic [WIDTH-1:0] m_tdata;
   logic             m_tlast;
   logic             m_tuser;
   logic [15:0]      pkt_seq;
   logic             short_pkt;

   la_axis_framer #(
      .WIDTH     (WIDTH),
      .MAX_BURST (MAX_BURST),
      .TMO_W     (TMO_W)
   ) dut (
      .axis_clk  (axis_clk),
      .axi_reset (axi_reset),
      .enable    (enable),
      .f_vld     (f_vld),
      .f_rdy     (f_rdy),
      .f_data    (f_data),
      .burst_len (burst_len),
      .tmo_reg   (tmo_reg),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tdata   (m_tdata),
      .m_tlast   (m_tlast),
      .m_tuser   (m_tuser),
      .pkt_seq   (pkt_seq),
      .short_pkt (short_pkt)
   );

   always #5 axis_clk = ~axis_clk;

   logic [WIDTH-1:0] fifo_q[$];
   beat_t            obs_q[$];
   beat_t            exp_q[$];
   int               obs_cyc[$];
   int               acc_cyc[$];
   int               cyc = 0;
   int               n_short, n_stall, n_stall_rdy, n_unstable;
   int               en_drop_at, ready_mode;
   logic             prev_stall;
   logic [WIDTH-1:0] prev_data;
   logic             prev_last;
   int               n_checks = 0;
   int               n_fail = 0;

   task automatic check_value(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] ent(input int tag, input int i);
      return (WIDTH'(tag) << 32) | WIDTH'(i);
   endfunction

   function automatic beat_t pay(input logic [WIDTH-1:0] d, input logic last);
      return {1'b0, last, d};
   endfunction

   task automatic exp_hdr(input int len, input int seq);
      if (HDR) exp_q.push_back({1'b1, 1'b0, WIDTH'((len << 16) | seq)});
   endtask

   task automatic drive();
      f_vld    = (fifo_q.size() > 0);
      f_data   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      m_tready = (ready_mode == 0) ? 1'b1 : cyc[0];
   endtask

   // One clock: sample everything at the falling edge, update stimulus
   // just after the rising edge
   task automatic tick();
      logic acc;
      @(negedge axis_clk);
      acc = 1'b0;
      if (!axi_reset) begin
         if (m_tvalid && m_tready) begin
            obs_q.push_back({m_tuser, m_tlast, m_tdata});
            obs_cyc.push_back(cyc);
         end
         if (f_vld && f_rdy) begin
            acc = 1'b1;
            acc_cyc.push_back(cyc);
         end
         if (short_pkt) n_short++;
         if (m_tvalid && !m_tready) n_stall++;
         if (m_tvalid && !m_tready && f_rdy) n_stall_rdy++;
         if (prev_stall && !(m_tvalid && m_tdata == prev_data && m_tlast == prev_last))
            n_unstable++;
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
      end
      @(posedge axis_clk);
      #1;
      cyc++;
      if (acc) void'(fifo_q.pop_front());
      if (en_drop_at >= 0 && acc_cyc.size() == en_drop_at) enable = 1'b0;
      drive();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic start_test();
      fifo_q.delete();
      obs_q.delete();
      exp_q.delete();
      obs_cyc.delete();
      acc_cyc.delete();
      n_short     = 0;
      n_stall     = 0;
      n_stall_rdy = 0;
      n_unstable  = 0;
      en_drop_at  = -1;
      ready_mode  = 0;
      prev_stall  = 1'b0;
      drive();
      enable = 1'b1;
   endtask

   task automatic check_stream(input string tag);
      beat_t o;
      check_value({tag, "_beats"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         o = '0;
         if (i < obs_q.size()) o = obs_q[i];
         check_value($sformatf("%s_b%0d", tag, i), 64'(o), 64'(exp_q[i]));
      end
   endtask

   initial begin
      start_test();
      enable    = 1'b0;
      axi_reset = 1'b1;
      run(2);
      axi_reset = 1'b0;
      drive();
      #1;
      check_value("rst_tvalid", 64'(m_tvalid), 0);
      check_value("rst_tlast", 64'(m_tlast), 0);
      check_value("rst_tuser", 64'(m_tuser), 0);
      check_value("rst_tdata", 64'(m_tdata), 0);
      check_value("rst_seq", 64'(pkt_seq), 0);
      check_value("rst_short", 64'(short_pkt), 0);
      check_value("rst_frdy_dis", 64'(f_rdy), 0);
      enable = 1'b1;
      #1;
      check_value("idle_frdy", 64'(f_rdy), 1);

      // Full packet of 4, continuous traffic
      start_test();
      burst_len = 8'd4;
      tmo_reg   = '0;
      for (int i = 0; i < 4; i++) fifo_q.push_back(ent(1, i));
      drive();
      run(15);
      exp_hdr(4, 0);
      for (int i = 0; i < 4; i++) exp_q.push_back(pay(ent(1, i), i == 3));
      check_stream("t1");
      check_value("t1_seq", 64'(pkt_seq), 1);
      if (acc_cyc.size() >= 4 && obs_cyc.size() > 0)
         check_value("t1_last_lat", 64'(obs_cyc[obs_cyc.size()-1] - acc_cyc[3]), 2);
      else
         check_value("t1_last_lat_missing", 64'(acc_cyc.size()), 4);

      // Timeout closes a 2-entry packet 6 cycles after the last accept
      start_test();
      burst_len = 8'd4;
      tmo_reg   = 8'd5;
      for (int i = 0; i < 2; i++) fifo_q.push_back(ent(2, i));
      drive();
      run(15);
      exp_hdr(4, 1);
      exp_q.push_back(pay(ent(2, 0), 1'b0));
      exp_q.push_back(pay(ent(2, 1), 1'b1));
      check_stream("t2");
      check_value("t2_short", 64'(n_short), 1);
      check_value("t2_seq", 64'(pkt_seq), 2);
      if (acc_cyc.size() >= 2 && obs_cyc.size() > 0)
         check_value("t2_tmo_lat", 64'(obs_cyc[obs_cyc.size()-1] - acc_cyc[1] - 1), 6);
      else
         check_value("t2_tmo_lat_missing", 64'(acc_cyc.size()), 2);
      tmo_reg = '0;

      // Back-pressure with m_tready toggling, packets of 3
      start_test();
      ready_mode = 1;
      burst_len  = 8'd3;
      for (int i = 0; i < 6; i++) fifo_q.push_back(ent(3, i));
      drive();
      run(40);
      ready_mode = 0;
      drive();
      exp_hdr(3, 2);
      for (int i = 0; i < 3; i++) exp_q.push_back(pay(ent(3, i), i == 2));
      exp_hdr(3, 3);
      for (int i = 3; i < 6; i++) exp_q.push_back(pay(ent(3, i), i == 5));
      check_stream("t3");
      check_value("t3_stalled", 64'(n_stall > 0), 1);
      check_value("t3_unstable", 64'(n_unstable), 0);
      check_value("t3_frdy_stall", 64'(n_stall_rdy), 0);
      check_value("t3_seq", 64'(pkt_seq), 4);

      // Length clamps: 0 -> 1 beat, 200 -> MAX_BURST beats
      start_test();
      burst_len = 8'd0;
      fifo_q.push_back(ent(4, 0));
      drive();
      run(6);
      exp_hdr(1, 4);
      exp_q.push_back(pay(ent(4, 0), 1'b1));
      burst_len = 8'd200;
      for (int i = 0; i < 16; i++) fifo_q.push_back(ent(5, i));
      drive();
      run(30);
      exp_hdr(16, 5);
      for (int i = 0; i < 16; i++) exp_q.push_back(pay(ent(5, i), i == 15));
      check_stream("t4");
      check_value("t4_seq", 64'(pkt_seq), 6);

      // Enable drops after the 2nd accept: packet of 8 still completes
      start_test();
      burst_len  = 8'd8;
      en_drop_at = 2;
      for (int i = 0; i < 10; i++) fifo_q.push_back(ent(6, i));
      drive();
      run(30);
      exp_hdr(8, 6);
      for (int i = 0; i < 8; i++) exp_q.push_back(pay(ent(6, i), i == 7));
      check_stream("t5");
      check_value("t5_accepts", 64'(acc_cyc.size()), 8);
      check_value("t5_fifo_left", 64'(fifo_q.size()), 2);
      check_value("t5_frdy", 64'(f_rdy), 0);
      check_value("t5_seq", 64'(pkt_seq), 7);

      // Reset in the middle of a packet
      start_test();
      burst_len = 8'd1;
      fifo_q.push_back(ent(7, 0));
      drive();
      run(6);
      check_value("t6_seq_pre", 64'(pkt_seq), 8);
      burst_len = 8'd4;
      for (int i = 0; i < 3; i++) fifo_q.push_back(ent(8, i));
      drive();
      run(3);
      check_value("t6_mid_tvalid", 64'(m_tvalid), 1);
      axi_reset = 1'b1;
      run(1);
      check_value("t6_rst_tvalid", 64'(m_tvalid), 0);
      check_value("t6_rst_seq", 64'(pkt_seq), 0);
      axi_reset = 1'b0;
      start_test();
      #1;
      check_value("t6_idle_frdy", 64'(f_rdy), 1);
      burst_len = 8'd1;
      fifo_q.push_back(ent(9, 0));
      drive();
      run(6);
      exp_hdr(1, 0);
      exp_q.push_back(pay(ent(9, 0), 1'b1));
      check_stream("t6");
      check_value("t6_seq_post", 64'(pkt_seq), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
